// File: rtl/dmem_pkg.sv
// Shared funct3 encodings, FSM state type and a funct3 legality helper for the data-memory responder.
// Pure declarations: no latency or backpressure of its own.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

   function automatic logic f3_legal(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte/half/word lane steering: merges store data into a word and extracts/extends load data.
// Purely combinational, zero latency, no backpressure.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   output logic [31:0] st_word,
   output logic [31:0] ld_data,
   output logic        bad
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      ld_byte = word[{addr_lo, 3'b000} +: 8];
      ld_half = addr_lo[1] ? word[31:16] : word[15:0];
   end

   // Unsupported funct3 leaves the word untouched and loads as zero.
   always_comb begin
      st_word = word;
      ld_data = '0;
      bad     = ~f3_legal(funct3);
      case (funct3)
         F3_B: begin
            st_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            ld_data = {{24{ld_byte[7]}}, ld_byte};
         end
         F3_BU: begin
            st_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            ld_data = {24'h0, ld_byte};
         end
         F3_H: begin
            if (addr_lo[1]) st_word[31:16] = wdata[15:0];
            else            st_word[15:0]  = wdata[15:0];
            ld_data = {{16{ld_half[15]}}, ld_half};
            bad     = addr_lo[0];
         end
         F3_HU: begin
            if (addr_lo[1]) st_word[31:16] = wdata[15:0];
            else            st_word[15:0]  = wdata[15:0];
            ld_data = {16'h0, ld_half};
            bad     = addr_lo[0];
         end
         F3_W: begin
            st_word = wdata;
            ld_data = word;
            bad     = (addr_lo != 2'b00);
         end
         default: begin
            st_word = word;
            ld_data = '0;
         end
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data responder: one load/store in flight, response LAT cycles after accept.
// req_ready only in IDLE; rsp held until rsp_ready. Optional trap on misalign: DMEM_MISALIGN_TRAP_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32,
   parameter int LAT    = 2
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [2:0]        req_funct3,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int         DEPTH    = 2**(ADDR_W-2);
   localparam logic [3:0] CNT_INIT = 4'(LAT-1);

`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   dmem_state_t       state, state_nxt;
   logic [3:0]        cnt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-3:0] widx;
   logic              accept;
   logic              trap;
   logic              bad;
   logic [31:0]       st_word;
   logic [31:0]       ld_data;

   assign widx   = req_addr[ADDR_W-1:2];
   assign accept = req_valid & req_ready;
   assign trap   = TRAP_EN & bad;

   dmem_lane_align u_align (
      .word    (mem[widx]),
      .addr_lo (req_addr[1:0]),
      .funct3  (req_funct3),
      .wdata   (req_wdata),
      .st_word (st_word),
      .ld_data (ld_data),
      .bad     (bad)
   );

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = (LAT == 1) ? RESP : WAIT;
         end
         WAIT: begin
            if (cnt == 4'd1) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Load data is extended at accept and parked here, so it stays stable through RESP and after.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt       <= CNT_INIT;
            rsp_rdata <= (req_we | trap) ? '0 : ld_data;
            rsp_err   <= trap;
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (accept & req_we & ~trap) begin
         mem[widx] <= st_word;
      end
   end

endmodule
